// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-order tagged forwarding buffer with stall and retire; FWD_SCOREBOARD_RES_BYPASS_EN forwards a same-cycle result
module fwd_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_rd,
  output logic                        issue_ready,
  output logic [TAG_W-1:0]            issue_tag,
  input  logic                        res_valid,
  input  logic [TAG_W-1:0]            res_tag,
  input  logic [DATA_W-1:0]           res_data,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   src_ori,
  output logic [NUM_SRC*DATA_W-1:0]   src_out,
  output logic                        stall,
  input  logic                        retire,
  output logic                        retire_valid,
  output logic [REG_AW-1:0]           retire_rd,
  output logic [DATA_W-1:0]           retire_data
);
  localparam int CW = TAG_W + 1;
  logic [DEPTH-1:0]  valid, ready;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head, tail, idx, ft;
  logic [CW-1:0]     count;
  logic              found, issue_acc, ret_acc;
  assign issue_ready = count != CW'(DEPTH);
  assign issue_tag   = tail;
  assign issue_acc   = issue_valid && issue_ready;
  assign ret_acc     = retire && count != '0 && ready[head];
  always_comb begin
    src_out = src_ori;
    stall   = 1'b0;
    found   = 1'b0;
    ft      = '0;
    idx     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      found = 1'b0;
      ft    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + TAG_W'(i);
        if (valid[idx] && rd_q[idx] == src_addr[s*REG_AW +: REG_AW]) begin
          found = 1'b1;
          ft    = idx;
        end
      end
      if (found && src_addr[s*REG_AW +: REG_AW] != '0) begin
        if (ready[ft]) src_out[s*DATA_W +: DATA_W] = data_q[ft];
`ifdef FWD_SCOREBOARD_RES_BYPASS_EN
        else if (res_valid && res_tag == ft) src_out[s*DATA_W +: DATA_W] = res_data;
`endif
        else stall = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid        <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (issue_acc) begin
        valid[tail]  <= 1'b1;
        ready[tail]  <= 1'b0;
        rd_q[tail]   <= issue_rd;
        data_q[tail] <= '0;
        tail         <= tail + 1'b1;
      end
      if (res_valid && valid[res_tag] && !ready[res_tag]) begin
        ready[res_tag]  <= 1'b1;
        data_q[res_tag] <= res_data;
      end
      if (ret_acc) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        retire_rd   <= rd_q[head];
        retire_data <= data_q[head];
      end
      retire_valid <= ret_acc;
      count        <= count + CW'(issue_acc) - CW'(ret_acc);
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, issue_valid, issue_ready, res_valid, stall, retire, retire_valid;
  logic [4:0]  issue_rd, retire_rd;
  logic [1:0]  issue_tag, res_tag;
  logic [31:0] res_data, retire_data;
  logic [9:0]  src_addr;
  logic [63:0] src_ori, src_out;
  int checks = 0, failures = 0;
  fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag), .res_valid(res_valid),
    .res_tag(res_tag), .res_data(res_data), .src_addr(src_addr), .src_ori(src_ori),
    .src_out(src_out), .stall(stall), .retire(retire), .retire_valid(retire_valid),
    .retire_rd(retire_rd), .retire_data(retire_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic issue(input logic [4:0] r);
    issue_valid = 1'b1;
    issue_rd    = r;
    tick();
    issue_valid = 1'b0;
  endtask
  task automatic result(input logic [1:0] t, input logic [31:0] d);
    res_valid = 1'b1;
    res_tag   = t;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; res_valid = 1'b0; res_tag = '0;
    res_data = '0; retire = 1'b0; src_addr = {5'd2, 5'd1}; src_ori = {32'h22, 32'h11};
    tick();
    do_reset();
    #1;
    chk("idle_src_out", src_out, {32'h22, 32'h11});
    chk("idle_stall", stall, 0);
    chk("idle_issue_ready", issue_ready, 1);
    chk("idle_retire_valid", retire_valid, 0);
    chk("idle_issue_tag", issue_tag, 0);
    issue(5'd3);
    src_addr = {5'd2, 5'd3};
    #1;
    chk("r3_unready_stall", stall, 1);
    chk("r3_unready_src", src_out, {32'h22, 32'h11});
    chk("r3_tag_advance", issue_tag, 1);
    res_valid = 1'b1; res_tag = 2'd0; res_data = 32'hDEAD;
    #1;
`ifdef FWD_SCOREBOARD_RES_BYPASS_EN
    chk("r3_bypass_stall", stall, 0);
    chk("r3_bypass_src", src_out, {32'h22, 32'hDEAD});
`else
    chk("r3_nobypass_stall", stall, 1);
    chk("r3_nobypass_src", src_out, {32'h22, 32'h11});
`endif
    tick();
    res_valid = 1'b0;
    #1;
    chk("r3_fwd_src", src_out, {32'h22, 32'hDEAD});
    chk("r3_fwd_stall", stall, 0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("r3_retire_valid", retire_valid, 1);
    chk("r3_retire_rd", retire_rd, 3);
    chk("r3_retire_data", retire_data, 32'hDEAD);
    do_reset();
    src_addr = {5'd2, 5'd5};
    issue(5'd5);
    chk("r5_tag1", issue_tag, 1);
    issue(5'd5);
    result(2'd0, 32'hA);
    result(2'd1, 32'hB);
    result(2'd1, 32'hFF);
    #1;
    chk("r5_youngest", src_out, {32'h22, 32'hB});
    chk("r5_no_stall", stall, 0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("r5_retire_valid", retire_valid, 1);
    chk("r5_retire_rd", retire_rd, 5);
    chk("r5_retire_data", retire_data, 32'hA);
    chk("r5_still_youngest", src_out, {32'h22, 32'hB});
    tick();
    chk("r5_retire_valid_drop", retire_valid, 0);
    chk("r5_retire_data_hold", retire_data, 32'hA);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("r5_retire2_data", retire_data, 32'hB);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("fill_tag", issue_tag, i);
      issue(5'(8 + i));
    end
    chk("full_not_ready", issue_ready, 0);
    chk("full_tag_wrap", issue_tag, 0);
    issue(5'd12);
    chk("full_ignored_tag", issue_tag, 0);
    src_addr = {5'd9, 5'd12};
    src_ori  = {32'h99, 32'hCC};
    #1;
    chk("full_ignored_nomatch", src_out, {32'h99, 32'hCC});
    chk("full_stall_r9", stall, 1);
    for (int i = 0; i < 4; i++) result(2'(i), 32'h100 + i);
    #1;
    chk("full_fwd_r9", src_out, {32'h101, 32'hCC});
    retire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_data", retire_data, 32'h100 + i);
      chk("drain_rd", retire_rd, 8 + i);
    end
    retire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_tag", issue_tag, i);
      issue(5'(16 + i));
    end
    for (int i = 0; i < 4; i++) result(2'(i), 32'h200 + i);
    issue_valid = 1'b1; issue_rd = 5'd20; retire = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("full_issue_retire_tag", issue_tag, 0);
    chk("full_issue_retire_ready", issue_ready, 1);
    chk("full_issue_retire_rd", retire_rd, 16);
    for (int i = 0; i < 3; i++) tick();
    retire = 1'b0;
    chk("wrap_last_rd", retire_rd, 19);
    chk("wrap_last_data", retire_data, 32'h203);
    chk("empty_ready", issue_ready, 1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("empty_retire_valid", retire_valid, 0);
    chk("empty_retire_rd_hold", retire_rd, 19);
    issue(5'd0);
    result(2'd0, 32'h5);
    src_addr = {5'd2, 5'd0};
    src_ori  = {32'h22, 32'h0};
    #1;
    chk("r0_src", src_out, {32'h22, 32'h0});
    chk("r0_stall", stall, 0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("r0_retire_data", retire_data, 32'h5);
    issue(5'd7);
    src_addr = {5'd2, 5'd7};
    src_ori  = {32'h22, 32'h11};
    res_valid = 1'b1; res_tag = 2'd1; res_data = 32'h77;
    #1;
`ifdef FWD_SCOREBOARD_RES_BYPASS_EN
    chk("r7_bypass_src", src_out, {32'h22, 32'h77});
    chk("r7_bypass_stall", stall, 0);
`else
    chk("r7_nobypass_src", src_out, {32'h22, 32'h11});
    chk("r7_nobypass_stall", stall, 1);
`endif
    tick();
    res_valid = 1'b0;
    #1;
    chk("r7_fwd_src", src_out, {32'h22, 32'h77});
    chk("r7_fwd_stall", stall, 0);
    do_reset();
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    src_addr = {5'd2, 5'd1};
    #1;
    chk("pre_reset_stall", stall, 1);
    chk("pre_reset_tag", issue_tag, 3);
    do_reset();
    #1;
    chk("post_reset_stall", stall, 0);
    chk("post_reset_tag", issue_tag, 0);
    chk("post_reset_src", src_out, {32'h22, 32'h11});
    chk("post_reset_ready", issue_ready, 1);
    chk("post_reset_retire_data", retire_data, 0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("post_reset_retire_valid", retire_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
